// File: rtl/tm1637_pkg.sv
// tm1637_pkg: command constants, RAM depth and FSM state type for the TM1637 responder
package tm1637_pkg;
  localparam logic [1:0] CMD_DATA = 2'b01;
  localparam logic [1:0] CMD_DISP = 2'b10;
  localparam logic [1:0] CMD_ADDR = 2'b11;
  localparam int FIXED_BIT = 2;
  localparam logic [1:0] WR_CODE = 2'b00;
  localparam logic [1:0] RD_CODE = 2'b10;
  localparam int RAM_DEPTH = 6;
  typedef enum logic [2:0] {IDLE, CMD, ACK, DATA, KEYS, WAIT_STOP} state_t;
endpackage

// File: rtl/tm1637_sync_edge.sv
// tm1637_sync_edge: two-flop synchronizer followed by an edge register with rise/fall detect
module tm1637_sync_edge #(
  parameter logic RST = 1'b1
) (
  input  logic clk_50M,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic s1, prev;
  always_ff @(posedge clk_50M or negedge rst_n)
    if (!rst_n) {s1, q, prev} <= {3{RST}};
    else {s1, q, prev} <= {d, s1, q};
  assign rise = q && !prev;
  assign fall = !q && prev;
endmodule

// File: rtl/tm1637_responder.sv
// tm1637_responder: TM1637 bus responder with 6-byte display RAM; define TM1637_RESP_KEYSCAN_EN for the key-read command
module tm1637_responder
  import tm1637_pkg::*;
#(
  parameter int MIN_HALF = 8
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       tm_clk,
  input  logic       tm_dio_in,
  output logic       dio_oe,
  input  logic [2:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       disp_on,
  output logic [2:0] brightness,
  output logic       frame_done,
  output logic       err,
  input  logic [7:0] keys
);
  if (MIN_HALF < 4) begin : g_min_half
    $error("MIN_HALF too short to keep DIO stable around CLK rising edges");
  end
  logic clk_s, clk_r, clk_f, dio_s, dio_r, dio_f;
  tm1637_sync_edge u_clk (.clk_50M, .rst_n, .d(tm_clk), .q(clk_s), .rise(clk_r), .fall(clk_f));
  tm1637_sync_edge u_dio (.clk_50M, .rst_n, .d(tm_dio_in), .q(dio_s), .rise(dio_r), .fall(dio_f));
  state_t state, state_n, ret, cmd_ret;
  logic [7:0] sr, byte_in;
  logic [7:0] ram [RAM_DEPTH];
  logic [2:0] cnt, ptr, kcnt;
  logic fixed, ack_on, wrote, disp_pend;
  logic start, stop, rx, bit_done, is_wr, is_rd, cmd_bad, ptr_ok, key_drv;
`ifdef TM1637_RESP_KEYSCAN_EN
  assign is_rd = byte_in[7:6] == CMD_DATA && byte_in[1:0] == RD_CODE;
  assign key_drv = !keys[kcnt];
`else
  logic unused_keys;
  assign unused_keys = ^keys;
  assign is_rd = 1'b0;
  assign key_drv = 1'b0;
`endif
  always_comb begin
    start = dio_f && clk_s;
    stop = dio_r && clk_s;
    rx = state == CMD || state == DATA || state == WAIT_STOP;
    bit_done = clk_r && rx && cnt == 3'd7 && !start && !stop;
    byte_in = {dio_s, sr[7:1]};
    is_wr = byte_in[7:6] == CMD_DATA && byte_in[1:0] == WR_CODE;
    cmd_bad = !(is_wr || is_rd || byte_in[7:6] == CMD_ADDR || byte_in[7:6] == CMD_DISP);
    cmd_ret = byte_in[7:6] == CMD_ADDR ? DATA : is_rd ? KEYS : WAIT_STOP;
    ptr_ok = ptr < 3'(RAM_DEPTH);
  end
  // STOP outranks START; ACK leaves on its second falling edge
  always_comb begin
    state_n = stop ? IDLE
            : start ? CMD
            : bit_done ? ACK
            : (state == ACK && clk_f && ack_on) ? ret
            : (state == KEYS && clk_f && kcnt == 3'd0) ? WAIT_STOP
            : state;
  end
  always_ff @(posedge clk_50M or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk_50M or negedge rst_n)
    if (!rst_n) begin
      ret <= IDLE;
      sr <= '0;
      ram <= '{default: 8'h00};
      cnt <= '0;
      ptr <= '0;
      kcnt <= '0;
      fixed <= 1'b0;
      ack_on <= 1'b0;
      wrote <= 1'b0;
      disp_pend <= 1'b0;
      dio_oe <= 1'b0;
      disp_on <= 1'b0;
      brightness <= '0;
      frame_done <= 1'b0;
      err <= 1'b0;
    end else begin
      frame_done <= stop && wrote;
      err <= bit_done && (state == CMD ? cmd_bad : state == DATA && !ptr_ok);
      if (stop) begin
        dio_oe <= 1'b0;
        ack_on <= 1'b0;
      end else if (start) begin
        cnt <= '0;
        kcnt <= '0;
        dio_oe <= 1'b0;
        ack_on <= 1'b0;
        wrote <= 1'b0;
        disp_pend <= 1'b0;
      end else if (clk_r && rx) begin
        sr <= byte_in;
        cnt <= cnt + 3'd1;
        if (bit_done) begin
          ret <= state == CMD ? cmd_ret : state;
          disp_pend <= state == CMD && byte_in[7:6] == CMD_DISP;
          if (state == CMD && byte_in[7:6] == CMD_ADDR) ptr <= byte_in[2:0];
          if (state == CMD && is_wr) fixed <= byte_in[FIXED_BIT];
          if (state == DATA) begin
            if (ptr_ok) begin
              ram[ptr] <= byte_in;
              wrote <= 1'b1;
            end
            if (!fixed) ptr <= ptr + 3'd1;
          end
        end
      end else if (clk_f && state == ACK) begin
        ack_on <= !ack_on;
        dio_oe <= !ack_on || (ret == KEYS && key_drv);
        if (ack_on && ret == KEYS) kcnt <= kcnt + 3'd1;
        if (ack_on && disp_pend) {disp_on, brightness} <= sr[3:0];
      end else if (clk_f && state == KEYS) begin
        dio_oe <= kcnt != 3'd0 && key_drv;
        kcnt <= kcnt + 3'd1;
      end
    end
  assign rd_data = rd_addr < 3'(RAM_DEPTH) ? ram[rd_addr] : 8'h00;
endmodule

// File: tb/tb_tm1637_responder.sv
// tb_tm1637_responder: table-driven bus frames plus reset and key-read sequences
module tb_tm1637_responder;
  localparam int H = 8;
`ifdef TM1637_RESP_KEYSCAN_EN
  localparam int KS_ERR = 0;
`else
  localparam int KS_ERR = 1;
`endif
  typedef struct {
    int n;
    logic [47:0] bytes;
    logic on;
    logic [2:0] br;
    int fd;
    int er;
    logic [47:0] ram;
  } frame_t;
  logic clk_50M = 1'b0, rst_n = 1'b0, tm_clk = 1'b1, m_dio = 1'b1, tm_dio_in;
  logic dio_oe, disp_on, frame_done, err;
  logic [2:0] rd_addr = '0, brightness;
  logic [7:0] rd_data, keys = 8'hA5;
  int checks = 0, failures = 0, fd_cnt = 0, err_cnt = 0;
  frame_t tbl [14];
  assign tm_dio_in = m_dio && !dio_oe;
  always #10 clk_50M = ~clk_50M;
  tm1637_responder dut (.clk_50M, .rst_n, .tm_clk, .tm_dio_in, .dio_oe, .rd_addr, .rd_data,
                        .disp_on, .brightness, .frame_done, .err, .keys);
  always @(negedge clk_50M) begin
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk_50M);
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  task automatic start_c;
    m_dio = 1'b1;
    cyc(H);
    tm_clk = 1'b1;
    cyc(H);
    m_dio = 1'b0;
    cyc(H);
    tm_clk = 1'b0;
  endtask
  task automatic stop_c;
    cyc(H / 2);
    m_dio = 1'b0;
    cyc(H / 2);
    tm_clk = 1'b1;
    cyc(H);
    m_dio = 1'b1;
    cyc(H);
  endtask
  task automatic send_clk(input logic [7:0] b, input int nclk, output logic [8:0] ack);
    ack = '0;
    for (int i = 0; i < nclk; i++) begin
      cyc(H / 2);
      m_dio = i < 8 ? b[i] : 1'b1;
      cyc(H / 2);
      tm_clk = 1'b1;
      cyc(H / 2);
      ack[i] = dio_oe;
      cyc(H / 2);
      tm_clk = 1'b0;
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, " dio_oe"}, 32'(dio_oe), 0);
    chk({tag, " disp_on"}, 32'(disp_on), 0);
    chk({tag, " brightness"}, 32'(brightness), 0);
    chk({tag, " frame_done"}, 32'(frame_done), 0);
    chk({tag, " err"}, 32'(err), 0);
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      cyc(1);
      chk($sformatf("%s ram%0d", tag, a), 32'(rd_data), 0);
    end
  endtask
  initial begin
    logic [8:0] ack;
    logic [7:0] kv;
    int fd0, er0;
    tbl[0]  = '{1, 48'h40_00_00_00_00_00, 1'b0, 3'd0, 0, 0, 48'h00_00_00_00_00_00};
    tbl[1]  = '{5, 48'hC0_3F_06_5B_4F_00, 1'b0, 3'd0, 1, 0, 48'h3F_06_5B_4F_00_00};
    tbl[2]  = '{1, 48'h8F_00_00_00_00_00, 1'b1, 3'd7, 0, 0, 48'h3F_06_5B_4F_00_00};
    tbl[3]  = '{1, 48'h80_00_00_00_00_00, 1'b0, 3'd0, 0, 0, 48'h3F_06_5B_4F_00_00};
    tbl[4]  = '{1, 48'h44_00_00_00_00_00, 1'b0, 3'd0, 0, 0, 48'h3F_06_5B_4F_00_00};
    tbl[5]  = '{3, 48'hC3_66_77_00_00_00, 1'b0, 3'd0, 1, 0, 48'h3F_06_5B_77_00_00};
    tbl[6]  = '{1, 48'h40_00_00_00_00_00, 1'b0, 3'd0, 0, 0, 48'h3F_06_5B_77_00_00};
    tbl[7]  = '{6, 48'hC4_A1_A2_A3_A4_A5, 1'b0, 3'd0, 1, 2, 48'hA5_06_5B_77_A1_A2};
    tbl[8]  = '{2, 48'h20_11_00_00_00_00, 1'b0, 3'd0, 0, 1, 48'hA5_06_5B_77_A1_A2};
    tbl[9]  = '{1, 48'h41_00_00_00_00_00, 1'b0, 3'd0, 0, 1, 48'hA5_06_5B_77_A1_A2};
    tbl[10] = '{1, 48'h42_00_00_00_00_00, 1'b0, 3'd0, 0, KS_ERR, 48'hA5_06_5B_77_A1_A2};
    tbl[11] = '{2, 48'hC6_12_00_00_00_00, 1'b0, 3'd0, 0, 1, 48'hA5_06_5B_77_A1_A2};
    tbl[12] = '{3, 48'hC7_13_14_00_00_00, 1'b0, 3'd0, 1, 1, 48'h14_06_5B_77_A1_A2};
    tbl[13] = '{1, 48'h8A_00_00_00_00_00, 1'b1, 3'd2, 0, 0, 48'h14_06_5B_77_A1_A2};
    cyc(5);
    chk_idle("reset");
    rst_n = 1'b1;
    cyc(5);
    for (int f = 0; f < 14; f++) begin
      fd0 = fd_cnt;
      er0 = err_cnt;
      start_c;
      for (int i = 0; i < tbl[f].n; i++) begin
        send_clk(tbl[f].bytes[47-8*i -: 8], 9, ack);
        chk($sformatf("f%0d ack%0d", f, i), 32'(ack), 32'h100);
      end
      stop_c;
      cyc(4);
      chk($sformatf("f%0d disp_on", f), 32'(disp_on), 32'(tbl[f].on));
      chk($sformatf("f%0d brightness", f), 32'(brightness), 32'(tbl[f].br));
      chk($sformatf("f%0d frame_done", f), 32'(fd_cnt - fd0), 32'(tbl[f].fd));
      chk($sformatf("f%0d err", f), 32'(err_cnt - er0), 32'(tbl[f].er));
      for (int a = 0; a < 8; a++) begin
        rd_addr = 3'(a);
        cyc(1);
        chk($sformatf("f%0d ram%0d", f, a), 32'(rd_data), a < 6 ? 32'(tbl[f].ram[47-8*a -: 8]) : 0);
      end
    end
`ifdef TM1637_RESP_KEYSCAN_EN
    er0 = err_cnt;
    start_c;
    send_clk(8'h42, 9, ack);
    chk("keys ack", 32'(ack), 32'h100);
    kv = '0;
    for (int i = 0; i < 8; i++) begin
      cyc(H / 2);
      m_dio = 1'b1;
      cyc(H / 2);
      tm_clk = 1'b1;
      cyc(H / 2);
      kv[i] = tm_dio_in;
      cyc(H / 2);
      tm_clk = 1'b0;
    end
    cyc(6);
    chk("keys readback", 32'(kv), 32'hA5);
    chk("keys release", 32'(dio_oe), 0);
    stop_c;
    chk("keys err", 32'(err_cnt - er0), 0);
`endif
    start_c;
    send_clk(8'hC0, 8, ack);
    cyc(6);
    chk("pre-reset ack", 32'(dio_oe), 1);
    rst_n = 1'b0;
    cyc(2);
    chk_idle("midbyte reset");
    rst_n = 1'b1;
    cyc(4);
    fd0 = fd_cnt;
    er0 = err_cnt;
    start_c;
    send_clk(8'hC1, 9, ack);
    chk("resume ack0", 32'(ack), 32'h100);
    send_clk(8'h5A, 9, ack);
    chk("resume ack1", 32'(ack), 32'h100);
    stop_c;
    cyc(4);
    rd_addr = 3'd1;
    cyc(1);
    chk("resume ram1", 32'(rd_data), 32'h5A);
    rd_addr = 3'd0;
    cyc(1);
    chk("resume ram0", 32'(rd_data), 0);
    chk("resume frame_done", 32'(fd_cnt - fd0), 1);
    chk("resume err", 32'(err_cnt - er0), 0);
    chk("resume disp_on", 32'(disp_on), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
